if_id_stage: RTL and testbench
==============================

# if_id_stage

Fetch stage of the pipelined MIPS core. It holds the program counter, drives the instruction-memory address, and captures the fetched instruction and its PC+4 into the IF/ID pipeline register. It applies load-use stalls from the hazard unit, flushes, and branch/jump/jr redirects resolved in EX. Its outputs feed the decode stage, which drives the ID/EX register inputs.

## Interface
Parameters:
- pc_size, 18, PC/address width in bits (byte address)
- data_size, 32, instruction width

Ports:
- clk  in  1  core clock; all state updates on the falling edge, matching the other pipeline registers
- rst  in  1  asynchronous, active-low reset
- PCWrite  in  1  1 = PC may advance; 0 = hold PC (load-use stall)
- IF_IDWrite  in  1  1 = IF/ID may load; 0 = hold IF/ID
- IF_Flush  in  1  insert a bubble into IF/ID at the next edge
- redirect_valid  in  1  taken branch, jump or jr/jalr resolved in EX this cycle
- redirect_pc  in  pc_size  redirect target; bits [1:0] ignored
- IM_addr  out  pc_size  instruction-memory address; equals the current PC
- IM_instr  in  data_size  combinational instruction-memory read data for IM_addr
- ID_PC  out  pc_size  PC+4 of the instruction in ID
- ID_ir  out  data_size  instruction in ID
- ID_valid  out  1  ID holds a real instruction, not a bubble
- fetch_count  out  32  number of instructions accepted into IF/ID with valid=1

## Operation
- Reset (rst=0) takes effect immediately, independent of clk:
  - PC=0, ID_ir=0 (the sll $0 nop), ID_PC=0, ID_valid=0, fetch_count=0.
  - If asserted mid-stall or mid-redirect, reset wins and no pending action survives.
  - First fetch is from address 0 after reset is released.
- pc_plus4 = PC + 4, modulo 2^pc_size. 0x3FFFC wraps to 0x00000.
- Bubble = {ID_ir=0, ID_PC=0, ID_valid=0}.
- Per falling edge, first matching rule wins:
  1. redirect_valid=1:
     - PC <= {redirect_pc[pc_size-1:2], 2'b00}.
     - IF/ID <= bubble.
     - Overrides PCWrite=0, IF_IDWrite=0 and IF_Flush. The redirecting instruction is older than anything stalled in ID, so the stalled instruction is wrong-path.
  2. IF_Flush=1:
     - IF/ID <= bubble.
     - PC <= pc_plus4 if PCWrite=1, else hold.
  3. Otherwise:
     - PC <= pc_plus4 if PCWrite=1, else hold.
     - If IF_IDWrite=1: IF/ID <= {IM_instr, pc_plus4, 1}. Otherwise hold all three fields.
- PCWrite=1 with IF_IDWrite=0 is legal. PC advances and IF/ID holds, so the fetched instruction is dropped. The hazard unit never issues this combination, but the block must behave exactly as stated.
- fetch_count increments by 1, wrapping at 2^32, on every edge where rule 3 loads IF/ID. Holds, bubbles and reset do not increment it.

## Timing
- IM_addr follows the PC register with no added delay. IM_instr is sampled on the same falling edge that advances the PC.
- Fetch-to-ID latency: 1 edge. An instruction at address A is in ID_ir after the edge where PC=A.
- Redirect: redirect_valid sampled at edge N sets PC to the target. The target instruction appears in ID at edge N+1. ID holds a bubble between N and N+1.
- Stall: with PCWrite=0 and IF_IDWrite=0, PC and IF/ID are unchanged for as many cycles as held. Release resumes with no lost or duplicated instruction.
- No combinational path from any input to any output other than IM_addr, which depends only on state.

## Structure
- Shared package (core-wide): pc_size, data_size, NOP_INSTR (32'h0000_0000), PC_STEP (4).
- One sub-module, pc_reg: pc_size-bit register with async active-low reset, hold and load. Next-value muxing stays in if_id_stage.
- The IF/ID register and fetch_count live in if_id_stage.

## Test plan
- Reset then free-run with IM returning instruction = address: ID_PC sequence 0x4, 0x8, 0xC; ID_valid=1 from the first edge; fetch_count=3 after 3 edges.
- Stall 2 cycles with PC=0x10: PC, ID_ir and ID_PC are frozen. On release, ID sees 0x10 then 0x14 with no gap. fetch_count is unchanged during the stall.
- redirect_valid with redirect_pc=0x123 while PCWrite=0 and IF_IDWrite=0: PC=0x120, ID_valid=0. Next edge: ID_ir = IM[0x120] and ID_PC=0x124.
- IF_Flush with PCWrite=1: bubble in ID (ID_ir=0, ID_valid=0), PC advances by 4, fetch_count unchanged.
- PC=0x3FFFC: next PC=0x00000 and ID_PC=0x00000.
- rst pulled low between clock edges mid-stream: all outputs read zero immediately. After release, fetch restarts from 0.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Core-wide constants shared by the pipeline stages.
// Fetch and decode widths and the canonical nop.
package if_id_stage_pkg;

  localparam int pc_size   = 18;
  localparam int data_size = 32;
  localparam int PC_STEP   = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter register.
// Async active-low clear, falling-edge load.
module pc_reg #(
  parameter int pc_size = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [pc_size-1:0] d,
  output logic [pc_size-1:0] q
);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC, IM address and the IF/ID register.
// Redirects from EX override stalls and flushes.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int pc_size   = if_id_stage_pkg::pc_size,
  parameter int data_size = if_id_stage_pkg::data_size
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCWrite,
  input  logic                 IF_IDWrite,
  input  logic                 IF_Flush,
  input  logic                 redirect_valid,
  input  logic [pc_size-1:0]   redirect_pc,
  output logic [pc_size-1:0]   IM_addr,
  input  logic [data_size-1:0] IM_instr,
  output logic [pc_size-1:0]   ID_PC,
  output logic [data_size-1:0] ID_ir,
  output logic                 ID_valid,
  output logic [31:0]          fetch_count
);

  logic [pc_size-1:0] pc;
  logic [pc_size-1:0] pc_plus4;
  logic [pc_size-1:0] pc_next;
  logic               pc_load;
  logic               bubble;
  logic               fetch;
  logic               unused_low;

  assign unused_low = ^redirect_pc[1:0];

  assign pc_plus4 = pc + pc_size'(PC_STEP);
  assign pc_load  = redirect_valid | PCWrite;
  assign pc_next  = redirect_valid
                  ? {redirect_pc[pc_size-1:2], 2'b00}
                  : pc_plus4;

  assign bubble = redirect_valid | IF_Flush;
  assign fetch  = !bubble && IF_IDWrite;

  pc_reg #(
    .pc_size(pc_size)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .d   (pc_next),
    .q   (pc)
  );

  assign IM_addr = pc;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ID_ir    <= data_size'(NOP_INSTR);
      ID_PC    <= '0;
      ID_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        bubble: begin
          ID_ir    <= data_size'(NOP_INSTR);
          ID_PC    <= '0;
          ID_valid <= 1'b0;
        end
        fetch: begin
          ID_ir    <= IM_instr;
          ID_PC    <= pc_plus4;
          ID_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (fetch) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage.
// IM model returns the fetch address as the instruction.
module tb_if_id_stage;

  localparam int PW = 18;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          pc_write;
  logic          ifid_write;
  logic          flush;
  logic          rv;
  logic [PW-1:0] rpc;
  logic [PW-1:0] im_addr;
  logic [DW-1:0] im_instr;
  logic [PW-1:0] id_pc;
  logic [DW-1:0] id_ir;
  logic          id_valid;
  logic [31:0]   fcount;

  int total = 0;
  int bad   = 0;

  if_id_stage #(
    .pc_size  (PW),
    .data_size(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (pc_write),
    .IF_IDWrite    (ifid_write),
    .IF_Flush      (flush),
    .redirect_valid(rv),
    .redirect_pc   (rpc),
    .IM_addr       (im_addr),
    .IM_instr      (im_instr),
    .ID_PC         (id_pc),
    .ID_ir         (id_ir),
    .ID_valid      (id_valid),
    .fetch_count   (fcount)
  );

  assign im_instr = DW'(im_addr);

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_id(
    input string       tag,
    input logic [31:0] ir,
    input logic [31:0] pc4,
    input logic        v
  );
    chk({tag, "_ir"}, id_ir, ir);
    chk({tag, "_pc"}, 32'(id_pc), pc4);
    chk({tag, "_v"}, 32'(id_valid), 32'(v));
  endtask

  initial begin
    rst        = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    flush      = 1'b0;
    rv         = 1'b0;
    rpc        = '0;
    #3;
    chk("rst_addr", 32'(im_addr), 32'h0);
    chk_id("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_cnt", fcount, 32'd0);
    #9 rst = 1'b1;

    tick();
    chk_id("run1", 32'h0, 32'h4, 1'b1);
    tick();
    chk_id("run2", 32'h4, 32'h8, 1'b1);
    tick();
    chk_id("run3", 32'h8, 32'hC, 1'b1);
    chk("run3_cnt", fcount, 32'd3);
    tick();
    chk("run4_addr", 32'(im_addr), 32'h10);

    pc_write   = 1'b0;
    ifid_write = 1'b0;
    tick();
    tick();
    chk("stall_addr", 32'(im_addr), 32'h10);
    chk_id("stall", 32'hC, 32'h10, 1'b1);
    chk("stall_cnt", fcount, 32'd4);
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    tick();
    chk_id("rel1", 32'h10, 32'h14, 1'b1);
    tick();
    chk_id("rel2", 32'h14, 32'h18, 1'b1);
    chk("rel_cnt", fcount, 32'd6);

    pc_write   = 1'b0;
    ifid_write = 1'b0;
    rv         = 1'b1;
    rpc        = 18'h123;
    tick();
    chk("redir_addr", 32'(im_addr), 32'h120);
    chk_id("redir", 32'h0, 32'h0, 1'b0);
    chk("redir_cnt", fcount, 32'd6);
    rv         = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    tick();
    chk_id("tgt", 32'h120, 32'h124, 1'b1);
    chk("tgt_cnt", fcount, 32'd7);

    flush = 1'b1;
    tick();
    chk_id("flush", 32'h0, 32'h0, 1'b0);
    chk("flush_addr", 32'(im_addr), 32'h128);
    chk("flush_cnt", fcount, 32'd7);
    flush = 1'b0;

    rv  = 1'b1;
    rpc = 18'h3FFFC;
    tick();
    chk("wrap_pre", 32'(im_addr), 32'h3FFFC);
    rv = 1'b0;
    tick();
    chk("wrap_addr", 32'(im_addr), 32'h0);
    chk_id("wrap", 32'h3FFFC, 32'h0, 1'b1);
    chk("wrap_cnt", fcount, 32'd8);

    ifid_write = 1'b0;
    tick();
    chk("drop_addr", 32'(im_addr), 32'h4);
    chk_id("drop", 32'h3FFFC, 32'h0, 1'b1);
    chk("drop_cnt", fcount, 32'd8);

    pc_write = 1'b0;
    tick();
    rv  = 1'b1;
    rpc = 18'h200;
    #3 rst = 1'b0;
    #1;
    chk("mrst_addr", 32'(im_addr), 32'h0);
    chk_id("mrst", 32'h0, 32'h0, 1'b0);
    chk("mrst_cnt", fcount, 32'd0);
    #2;
    rv         = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    rst        = 1'b1;
    tick();
    chk_id("restart", 32'h0, 32'h4, 1'b1);
    chk("restart_cnt", fcount, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
